// File: rtl/aud_pkg.sv
// Shared audio-path definitions: recorder FSM states and the sample/address widths
// common to the capture recorder and the playback DSP.
package aud_pkg;
  localparam int AUD_DATA_W = 16;
  localparam int AUD_ADDR_W = 20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SHIFT,
    S_WRITE,
    S_PAUSE
  } aud_state_e;
endpackage

// File: rtl/aud_if.sv
// SRAM write port of the audio recorder. Handshake: the slave must accept
// o_address/o_data in every cycle o_we is 1; there is no back-pressure.
interface aud_if
  import aud_pkg::*;
#(
  parameter int DATA_W = AUD_DATA_W,
  parameter int ADDR_W = AUD_ADDR_W
);
  logic [ADDR_W-1:0] o_address;
  logic [DATA_W-1:0] o_data;
  logic              o_we;

  modport master (output o_address, output o_data, output o_we);
  modport slave  (input  o_address, input  o_data, input  o_we);
endinterface

// File: rtl/aud_i2s_deser.sv
// I2S left-word deserialiser: LRC falling-edge detect (the 1-bit delay slot),
// MSB-first shift register and bit counter, sequenced by the recorder FSM.
module aud_i2s_deser
  import aud_pkg::*;
#(
  parameter int DATA_W = AUD_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_hunt,
  input  logic              i_shift,
  input  logic              i_lrc,
  input  logic              i_data,
  output logic              o_slot,
  output logic              o_word_valid,
  output logic [DATA_W-1:0] o_word
);
  localparam int CNT_W = $clog2(DATA_W);

  logic              lrc_q;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;

  // The slot cycle itself carries the previous word's last bit, so it is not shifted.
  assign o_slot       = i_hunt & lrc_q & ~i_lrc;
  assign o_word       = {shreg_q[DATA_W-2:0], i_data};
  assign o_word_valid = i_shift & (bitcnt_q == CNT_W'(DATA_W - 1));

  always_comb begin
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    if (o_slot) begin
      bitcnt_d = '0;
    end else if (i_shift) begin
      shreg_d  = {shreg_q[DATA_W-2:0], i_data};
      bitcnt_d = bitcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      lrc_q    <= 1'b1;
      shreg_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      lrc_q    <= i_lrc;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
    end
  end
endmodule

// File: rtl/aud_recorder.sv
// Audio capture recorder: writes one left-channel I2S sample per frame into SRAM
// and tracks the take length for playback.
module aud_recorder
  import aud_pkg::*;
#(
  parameter int              DATA_W   = AUD_DATA_W,
  parameter int              ADDR_W   = AUD_ADDR_W,
  parameter logic [ADDR_W-1:0] MAX_ADDR = '1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_pause,
  input  logic          i_stop,
  input  logic          i_lrc,
  input  logic          i_data,
  aud_if.master         sram,
  output logic [ADDR_W:0] o_len,
  output logic          o_full,
  output logic          o_busy,
  output aud_state_e    o_state
);
  localparam int LEN_W = ADDR_W + 1;

  aud_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              full_q, full_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] address_q, address_d;

  logic              slot;
  logic              word_valid;
  logic [DATA_W-1:0] word;

  aud_i2s_deser #(.DATA_W(DATA_W)) u_deser (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_hunt       (state_q == S_WAIT),
    .i_shift      (state_q == S_SHIFT),
    .i_lrc        (i_lrc),
    .i_data       (i_data),
    .o_slot       (slot),
    .o_word_valid (word_valid),
    .o_word       (word)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    full_d    = full_q;
    we_d      = 1'b0;
    data_d    = data_q;
    address_d = address_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          addr_d  = '0;
          len_d   = '0;
          full_d  = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_stop)       state_d = S_IDLE;
        else if (i_pause) state_d = S_PAUSE;
        else if (slot)    state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (i_stop) begin
          state_d = S_IDLE;
        end else if (i_pause) begin
          state_d = S_PAUSE;
        end else if (word_valid) begin
          we_d      = 1'b1;
          data_d    = word;
          address_d = addr_q;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        // The strobe is already on the bus; stop/pause only pick the next state.
        len_d = LEN_W'(addr_q) + LEN_W'(1);
        if (addr_q == MAX_ADDR) begin
          full_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          if (i_stop)       state_d = S_IDLE;
          else if (i_pause) state_d = S_PAUSE;
          else              state_d = S_WAIT;
        end
      end
      S_PAUSE: begin
        if (i_stop)       state_d = S_IDLE;
        else if (i_start) state_d = S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      full_q    <= 1'b0;
      we_q      <= 1'b0;
      data_q    <= '0;
      address_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      full_q    <= full_d;
      we_q      <= we_d;
      data_q    <= data_d;
      address_q <= address_d;
    end
  end

  assign sram.o_we      = we_q;
  assign sram.o_data    = data_q;
  assign sram.o_address = address_q;
  assign o_len          = len_q;
  assign o_full         = full_q;
  assign o_busy         = (state_q != S_IDLE) && (state_q != S_PAUSE);
  assign o_state        = state_q;
endmodule
